// File: rtl/bram_arb_pkg.sv
// ---------------------------------------------------------------------------
// bram_arb_pkg
// Shared types and helpers for the BRAM write arbiter.
//   state_t    : controller states (IDLE arbitrates, CLEAR sweeps memory)
//   rr_pick_t  : result of a round-robin search (found flag + winner index)
//   rr_winner(): round-robin winner from a valid vector and the last grant.
//                The search starts at (last+1) mod nreq and wraps once.
// No configuration macros are used in this file.
// ---------------------------------------------------------------------------
package bram_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int MAX_IDW = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } rr_pick_t;

  // Vectors are zero-extended to MAX_REQ by the caller so one function
  // serves every NREQ in 2..8. Positions k > nreq are never visited.
  function automatic rr_pick_t rr_winner(input logic [MAX_REQ-1:0] valid,
                                         input logic [MAX_IDW-1:0] last,
                                         input int                 nreq);
    rr_pick_t res;
    int       idx;
    res = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = (int'(last) + k) % nreq;
      if ((k <= nreq) && !res.found && valid[idx[MAX_IDW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = idx[MAX_IDW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bram_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// bram_wr_arbiter_if
// Bundle of the NREQ write requesters seen by the arbiter.
//   req_valid [NREQ]        : requester i wants to write
//   req_ready [NREQ]        : arbiter accepts requester i this cycle
//   req_addr  [NREQ*ADDRW]  : requester i at [i*ADDRW +: ADDRW]
//   req_data  [NREQ*WIDTH]  : requester i at [i*WIDTH +: WIDTH]
// Handshake: a write transfers in any cycle where req_valid[i] and
// req_ready[i] are both high. A requester keeps valid, addr and data stable
// until that happens; ready may depend combinationally on valid.
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface bram_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int ADDRW = 8,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*ADDRW-1:0] req_addr;
  logic [NREQ*WIDTH-1:0] req_data;

  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// NREQ-wide round-robin arbiter: combinational one-hot grant plus a
// registered last-grant pointer that advances only on an accepted grant.
//   clk, rst    : clock, synchronous active-high reset
//   i_valid     : request vector
//   i_enable    : arbitration allowed this cycle (0 forces no grant)
//   o_grant     : one-hot grant (ready to the winner)
//   o_grant_id  : index of the winner (meaningful when o_accept=1)
//   o_accept    : a grant is issued this cycle
// Reset puts the pointer at NREQ-1 so requester 0 is searched first.
// No configuration macros are used in this file.
// ---------------------------------------------------------------------------
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] i_valid,
  input  logic            i_enable,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grant_id,
  output logic            o_accept
);

  logic [IDW-1:0]     r_last_grant;
  logic [MAX_REQ-1:0] w_valid_ext;
  logic [MAX_IDW-1:0] w_last_ext;
  rr_pick_t           w_pick;

  always_comb begin
    w_valid_ext             = '0;
    w_valid_ext[NREQ-1:0]   = i_valid;
    w_last_ext              = '0;
    w_last_ext[IDW-1:0]     = r_last_grant;
  end

  assign w_pick     = rr_winner(w_valid_ext, w_last_ext, NREQ);
  assign o_accept   = i_enable && w_pick.found;
  assign o_grant_id = w_pick.idx[IDW-1:0];

  always_comb begin
    o_grant = '0;
    if (o_accept) begin
      o_grant[w_pick.idx[IDW-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= IDW'(NREQ - 1);
    end else if (o_accept) begin
      r_last_grant <= w_pick.idx[IDW-1:0];
    end
  end

endmodule

// File: rtl/bram_wr_arbiter.sv
// ---------------------------------------------------------------------------
// bram_wr_arbiter
// Round-robin write arbiter in front of port A of a simple dual-port BRAM,
// with an optional full-memory clear sweep.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   req_if       : requester bundle (slave modport), see bram_wr_arbiter_if
//   clear_start  : one-cycle pulse starting a clear sweep (IDLE only)
//   clear_data   : fill value, captured with an accepted clear_start
//   busy         : high while the clear sweep runs
//   bram_we/bram_addr/bram_din : registered BRAM port-A write
//   grant_id     : requester owning the current write (0 for clear writes)
//   o_dbg_state  : current controller state
// Configuration macro: BRAM_WR_ARB_CLEAR_EN compiles in the CLEAR state,
// the clear counter and busy. Without it clear_start/clear_data are ignored
// and busy is tied low.
// Timing: a transfer accepted in cycle N shows up as bram_we=1 in cycle N+1.
// Without a transfer bram_we=0 and addr/din/grant_id hold their values.
// ---------------------------------------------------------------------------
module bram_wr_arbiter
  import bram_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 256,
  localparam int ADDRW = $clog2(DEPTH),
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  bram_wr_arbiter_if.slave  req_if,
  input  logic              clear_start,
  input  logic [WIDTH-1:0]  clear_data,
  output logic              busy,
  output logic              bram_we,
  output logic [ADDRW-1:0]  bram_addr,
  output logic [WIDTH-1:0]  bram_din,
  output logic [IDW-1:0]    grant_id,
  output state_t            o_dbg_state
);

  state_t           r_state;
  logic             r_bram_we;
  logic [ADDRW-1:0] r_bram_addr;
  logic [WIDTH-1:0] r_bram_din;
  logic [IDW-1:0]   r_grant_id;

  logic             w_clear_go;
  logic             w_arb_en;
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_gid;
  logic             w_accept;
  logic [ADDRW-1:0] w_sel_addr;
  logic [WIDTH-1:0] w_sel_data;

`ifdef BRAM_WR_ARB_CLEAR_EN
  logic [ADDRW-1:0] r_clear_cnt;
  logic [WIDTH-1:0] r_clear_data;

  // A clear_start seen outside IDLE is simply not a clear_go, so a pulse
  // during a sweep neither restarts nor extends it.
  assign w_clear_go = (r_state == IDLE) && clear_start && !rst;
  assign busy       = (r_state == CLEAR);
`else
  logic w_unused_clear;

  assign w_unused_clear = ^{clear_start, clear_data};
  assign w_clear_go     = 1'b0;
  assign busy           = 1'b0;
`endif

  // A clear request wins over requesters in the same cycle; nothing is
  // granted while reset is applied.
  assign w_arb_en = (r_state == IDLE) && !w_clear_go && !rst;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (req_if.req_valid),
    .i_enable   (w_arb_en),
    .o_grant    (w_grant),
    .o_grant_id (w_gid),
    .o_accept   (w_accept)
  );

  assign req_if.req_ready = w_grant;
  assign w_sel_addr = req_if.req_addr[int'(w_gid)*ADDRW +: ADDRW];
  assign w_sel_data = req_if.req_data[int'(w_gid)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bram_we   <= 1'b0;
      r_bram_addr <= '0;
      r_bram_din  <= '0;
      r_grant_id  <= '0;
`ifdef BRAM_WR_ARB_CLEAR_EN
      r_clear_cnt  <= '0;
      r_clear_data <= '0;
`endif
    end else begin
      r_bram_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_bram_we   <= 1'b1;
            r_bram_addr <= w_sel_addr;
            r_bram_din  <= w_sel_data;
            r_grant_id  <= w_gid;
          end
`ifdef BRAM_WR_ARB_CLEAR_EN
          if (w_clear_go) begin
            r_state      <= CLEAR;
            r_clear_cnt  <= '0;
            r_clear_data <= clear_data;
          end
`endif
        end
`ifdef BRAM_WR_ARB_CLEAR_EN
        CLEAR: begin
          r_bram_we   <= 1'b1;
          r_bram_addr <= r_clear_cnt;
          r_bram_din  <= r_clear_data;
          r_grant_id  <= '0;
          // Compare against DEPTH-1 rather than relying on wrap, so a
          // non-power-of-two depth stops at its own last word.
          if (r_clear_cnt == ADDRW'(DEPTH - 1)) begin
            r_state     <= IDLE;
            r_clear_cnt <= '0;
          end else begin
            r_clear_cnt <= r_clear_cnt + ADDRW'(1);
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bram_we     = r_bram_we;
  assign bram_addr   = r_bram_addr;
  assign bram_din    = r_bram_din;
  assign grant_id    = r_grant_id;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bram_wr_arbiter.sv
module tb_bram_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 200;
  localparam int ADDRW = $clog2(DEPTH);
  localparam int IDW   = $clog2(NREQ);
  localparam int SBW   = IDW + ADDRW + WIDTH;
`ifdef BRAM_WR_ARB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              clear_start;
  logic [WIDTH-1:0]  clear_data;
  logic              busy;
  logic              bram_we;
  logic [ADDRW-1:0]  bram_addr;
  logic [WIDTH-1:0]  bram_din;
  logic [IDW-1:0]    grant_id;
  bram_arb_pkg::state_t dbg_state;

  bram_wr_arbiter_if #(.NREQ(NREQ), .ADDRW(ADDRW), .WIDTH(WIDTH)) rif ();

  bram_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_if      (rif),
    .clear_start (clear_start),
    .clear_data  (clear_data),
    .busy        (busy),
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_din    (bram_din),
    .grant_id    (grant_id),
    .o_dbg_state (dbg_state)
  );

  // ---------------- requesters and reference model ----------------
  logic             p_valid [NREQ];
  logic [ADDRW-1:0] p_addr  [NREQ];
  logic [WIDTH-1:0] p_data  [NREQ];

  int               m_last;
  bit               m_clearing;
  int               m_clr_addr;
  logic [WIDTH-1:0] m_clr_data;
  logic [ADDRW-1:0] m_addr;
  logic [WIDTH-1:0] m_din;
  logic [IDW-1:0]   m_gid;

  logic [SBW-1:0]   exp_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last     = NREQ - 1;
    m_clearing = 1'b0;
    m_clr_addr = 0;
    m_clr_data = '0;
    m_addr     = '0;
    m_din      = '0;
    m_gid      = '0;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      rif.req_valid[i]                 = p_valid[i];
      rif.req_addr[i*ADDRW +: ADDRW]   = p_addr[i];
      rif.req_data[i*WIDTH +: WIDTH]   = p_data[i];
    end
  endtask

  task automatic arm(input int i);
    p_valid[i] = 1'b1;
    p_addr[i]  = ADDRW'($urandom_range(DEPTH - 1));
    p_data[i]  = WIDTH'($urandom);
  endtask

  task automatic refill(input int pct);
    for (int i = 0; i < NREQ; i++) begin
      if (!p_valid[i] && ($urandom_range(99) < pct)) arm(i);
    end
  endtask

  task automatic drop_all();
    for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
  endtask

  // One clock cycle: called just after a falling edge, returns just after
  // the next falling edge. won = accepted requester, or -1.
  task automatic step(output int won);
    logic [NREQ-1:0] exp_ready;
    logic [SBW-1:0]  exp_w;
    bit              exp_we;
    drive_reqs();
    #1;
    won       = -1;
    exp_ready = '0;
    exp_we    = 1'b0;
    check("busy", 32'(busy), 32'(m_clearing));
    if (rst) begin
      model_reset();
    end else if (m_clearing) begin
      exp_we = 1'b1;
      m_addr = ADDRW'(m_clr_addr);
      m_din  = m_clr_data;
      m_gid  = '0;
      if (m_clr_addr == DEPTH - 1) m_clearing = 1'b0;
      else m_clr_addr++;
    end else if (CLEAR_EN && clear_start) begin
      m_clearing = 1'b1;
      m_clr_addr = 0;
      m_clr_data = clear_data;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (m_last + k) % NREQ;
        if (won < 0 && p_valid[idx]) won = idx;
      end
      if (won >= 0) begin
        exp_ready[won] = 1'b1;
        exp_we         = 1'b1;
        m_addr         = p_addr[won];
        m_din          = p_data[won];
        m_gid          = IDW'(won);
        m_last         = won;
      end
    end
    if (!rst) check("req_ready", 32'(rif.req_ready), 32'(exp_ready));
    if (exp_we) exp_q.push_back({m_gid, m_addr, m_din});
    @(posedge clk);
    #1;
    check("bram_we", 32'(bram_we), 32'(exp_we));
    if (exp_we) begin
      exp_w = exp_q.pop_front();
      check("bram_write", 32'({grant_id, bram_addr, bram_din}), 32'(exp_w));
    end else begin
      check("hold_addr", 32'(bram_addr), 32'(m_addr));
      check("hold_din", 32'(bram_din), 32'(m_din));
    end
    if (won >= 0) p_valid[won] = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int won;
    int busy_cnt;
    rst         = 1'b1;
    clear_start = 1'b0;
    clear_data  = '0;
    drop_all();
    for (int i = 0; i < NREQ; i++) begin
      p_addr[i] = '0;
      p_data[i] = '0;
    end
    drive_reqs();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);

    // reset state
    check("rst_we", 32'(bram_we), 32'd0);
    check("rst_addr", 32'(bram_addr), 32'd0);
    check("rst_din", 32'(bram_din), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(bram_arb_pkg::IDLE));
    rst = 1'b0;
    step(won);

    // all four requesters valid for 8 cycles: 0,1,2,3,0,1,2,3
    for (int i = 0; i < NREQ; i++) arm(i);
    for (int n = 0; n < 8; n++) begin
      step(won);
      check("rr_order", 32'(grant_id), 32'(n % NREQ));
      if (won >= 0) arm(won);
    end

    // only requester 2, fixed addr/data, three back-to-back writes
    drop_all();
    for (int n = 0; n < 3; n++) begin
      p_valid[2] = 1'b1;
      p_addr[2]  = ADDRW'(8'h10);
      p_data[2]  = WIDTH'(8'hAB);
      step(won);
      check("solo_gid", 32'(grant_id), 32'd2);
      check("solo_addr", 32'(bram_addr), 32'h10);
      check("solo_din", 32'(bram_din), 32'hAB);
    end
    drop_all();
    step(won);

    // random traffic; in the default build clear_start is also pulsed
    for (int n = 0; n < 250; n++) begin
      refill($urandom_range(90, 20));
      clear_start = !CLEAR_EN && ($urandom_range(15) == 0);
      clear_data  = WIDTH'($urandom);
      step(won);
    end
    clear_start = 1'b0;
    drop_all();
    step(won);

`ifdef BRAM_WR_ARB_CLEAR_EN
    // clear with requesters 0 and 1 waiting
    rst = 1'b1;
    step(won);
    rst = 1'b0;
    arm(0);
    arm(1);
    clear_start = 1'b1;
    clear_data  = '0;
    step(won);
    clear_start = 1'b0;
    busy_cnt = 0;
    for (int n = 0; n <= DEPTH; n++) begin
      if (busy === 1'b1) busy_cnt++;
      step(won);
    end
    check("clr_busy_len", 32'(busy_cnt), 32'(DEPTH));
    check("clr_first_we", 32'(bram_we), 32'd1);
    check("clr_first_gid", 32'(grant_id), 32'd0);
    drop_all();
    step(won);

    // second clear_start at address 50 is ignored
    clear_start = 1'b1;
    clear_data  = 8'h5A;
    step(won);
    busy_cnt = 0;
    for (int n = 0; n < DEPTH + 3; n++) begin
      clear_start = m_clearing && (m_clr_addr == 50);
      clear_data  = clear_start ? 8'hC3 : 8'h5A;
      if (busy === 1'b1) busy_cnt++;
      step(won);
    end
    clear_start = 1'b0;
    check("clr2_busy_len", 32'(busy_cnt), 32'(DEPTH));

    // reset at clear address 100 aborts the sweep
    clear_start = 1'b1;
    clear_data  = 8'h33;
    step(won);
    clear_start = 1'b0;
    for (int n = 0; n < DEPTH && !(m_clearing && m_clr_addr == 100); n++) step(won);
    rst = 1'b1;
    step(won);
    rst = 1'b0;
    check("abort_we", 32'(bram_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    arm(0);
    arm(2);
    step(won);
    check("abort_gnt_we", 32'(bram_we), 32'd1);
    check("abort_gnt_gid", 32'(grant_id), 32'd0);
    drop_all();
    step(won);
`else
    // clear_start without the clear feature: arbitration is unaffected
    arm(0);
    arm(1);
    clear_start = 1'b1;
    clear_data  = 8'hFF;
    step(won);
    clear_start = 1'b0;
    check("noclr_we", 32'(bram_we), 32'd1);
    for (int n = 0; n < 6; n++) begin
      step(won);
      check("noclr_busy", 32'(busy), 32'd0);
    end
    drop_all();
    step(won);
`endif

    // final report
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
